// File: rtl/multdiv_if.sv
// Operand/start and result/handshake bundle between the execute stage and multdiv_unit.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / restoring divide unit with overflow and divide-by-zero flag.
// Define MULTDIV_RADIX4_EN to build the multiplier as radix-4 Booth (16 steps instead of 32).
//
// state | meaning
// IDLE  | waiting for a start pulse, busy low
// MUL   | multiply iterations, last count finalises sign/overflow
// DIV   | divide iterations, count 0 also catches a zero divisor
// DONE  | one-cycle ready pulse, results valid
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic       clock,
    input logic       reset,
    multdiv_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

`ifdef MULTDIV_RADIX4_EN
    localparam int MUL_STEPS = WIDTH / 2;
`else
    localparam int MUL_STEPS = WIDTH;
`endif

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH:0]     mplier;
    logic [WIDTH:0]     rem;
    logic [WIDTH:0]     dvs;
    logic [WIDTH-1:0]   quo;
    logic               neg;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;

    logic               start;
    logic [WIDTH:0]     mag_a;
    logic [WIDTH:0]     mag_b;
    logic [2*WIDTH-1:0] acc_add;
    logic [2*WIDTH-1:0] prod_fin;
    logic               mul_exc;
    logic [WIDTH:0]     shifted;
    logic               div_ge;
    logic [WIDTH-1:0]   quo_fin;
    logic               div_exc;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;

    // 33-bit magnitudes so that 0x80000000 becomes 2**31 without wrapping
    assign mag_a = bus.data_operandA[WIDTH-1] ? ({1'b0, ~bus.data_operandA} + 1'b1)
                                              : {1'b0, bus.data_operandA};
    assign mag_b = bus.data_operandB[WIDTH-1] ? ({1'b0, ~bus.data_operandB} + 1'b1)
                                              : {1'b0, bus.data_operandB};

    always_comb begin
        acc_add = '0;
`ifdef MULTDIV_RADIX4_EN
        unique case (mplier[2:0])
            3'b001, 3'b010: acc_add = mcand;
            3'b011:         acc_add = mcand << 1;
            3'b100:         acc_add = -(mcand << 1);
            3'b101, 3'b110: acc_add = -mcand;
            default:        acc_add = '0;
        endcase
        prod_fin = acc;
`else
        if (mplier[0])
            acc_add = mcand;
        prod_fin = neg ? -acc : acc;
`endif
    end

    assign mul_exc = prod_fin[2*WIDTH-1:WIDTH] != {WIDTH{prod_fin[WIDTH-1]}};

    // partial remainder always stays below the divisor, so its top bit is never needed
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign div_ge  = shifted >= dvs;
    assign quo_fin = neg ? -quo : quo;
    assign div_exc = ~neg & quo[WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            dvs      <= '0;
            quo      <= '0;
            neg      <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (start) begin
            state <= bus.ctrl_MULT ? MUL : DIV;
            cnt   <= '0;
            acc   <= '0;
            neg   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
`ifdef MULTDIV_RADIX4_EN
            mcand  <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
            mplier <= {bus.data_operandB, 1'b0};
`else
            mcand  <= {{(WIDTH-1){1'b0}}, mag_a};
            mplier <= mag_b;
`endif
            rem   <= '0;
            quo   <= mag_a[WIDTH-1:0];
            dvs   <= mag_b;
        end else begin
            unique case (state)
                MUL: begin
                    if (cnt == CNT_W'(MUL_STEPS)) begin
                        result_q <= prod_fin[WIDTH-1:0];
                        exc_q    <= mul_exc;
                        state    <= DONE;
                    end else begin
                        acc <= acc + acc_add;
`ifdef MULTDIV_RADIX4_EN
                        mcand  <= mcand << 2;
                        mplier <= {{2{mplier[WIDTH]}}, mplier[WIDTH:2]};
`else
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
`endif
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (cnt == '0 && dvs == '0) begin
                        result_q <= '0;
                        exc_q    <= 1'b1;
                        state    <= DONE;
                    end else if (cnt == CNT_W'(WIDTH)) begin
                        result_q <= quo_fin;
                        exc_q    <= div_exc;
                        state    <= DONE;
                    end else begin
                        rem <= div_ge ? (shifted - dvs) : shifted;
                        quo <= {quo[WIDTH-2:0], div_ge};
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state == DONE);
    assign bus.busy           = (state != IDLE);
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit: arithmetic, ready timing, abort and reset.
module tb_multdiv_unit;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

`ifdef MULTDIV_RADIX4_EN
    localparam int MUL_CYC = 17;
`else
    localparam int MUL_CYC = 33;
`endif

    always #5 clock = ~clock;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic mul, input logic div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc, input int exp_cyc);
        int          rdy_cyc;
        int          pulses;
        logic [31:0] res;
        logic        exc;
        @(negedge clock);
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom();
        bus.data_operandB = $urandom();
        check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
        rdy_cyc = -1;
        pulses  = 0;
        res     = 'x;
        exc     = 1'bx;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) begin
                pulses++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = k;
                    res     = bus.data_result;
                    exc     = bus.data_exception;
                end
            end
        end
        check({tag, "_rdy_cycle"}, 64'(rdy_cyc), 64'(exp_cyc));
        check({tag, "_rdy_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_result"}, 64'(res), 64'(exp_res));
        check({tag, "_exception"}, 64'(exc), 64'(exp_exc));
        check({tag, "_held"}, 64'(bus.data_result), 64'(exp_res));
        check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int          pulses;
        int          rdy_cyc;
        logic [31:0] res;

        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_result", 64'(bus.data_result), 64'd0);
        check("rst_exception", 64'(bus.data_exception), 64'd0);
        check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, MUL_CYC);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, MUL_CYC);
        run_op("mul_m1_m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, MUL_CYC);
        run_op("mul_min_1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, MUL_CYC);
        run_op("div_m17_5", 1'b0, 1'b1, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("div_by_0", 1'b0, 1'b1, 32'd100, 32'd0, 32'd0, 1'b1, 1);
        run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
        run_op("div_1000_7", 1'b0, 1'b1, 32'd1000, 32'd7, 32'd142, 1'b0, 33);

        // MULT 3*4 aborted by DIV 20/4 at cycle 10
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd4;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        pulses  = 0;
        rdy_cyc = -1;
        res     = 'x;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) pulses++;
        end
        @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd20;
        bus.data_operandB = 32'd4;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        for (int k = 11; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) begin
                pulses++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = k;
                    res     = bus.data_result;
                end
            end
        end
        check("abort_rdy_cycle", 64'(rdy_cyc), 64'd43);
        check("abort_rdy_pulses", 64'(pulses), 64'd1);
        check("abort_result", 64'(res), 64'd5);

        // DIV in flight, reset asserted for the edge at cycle 12
        @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 32'd3;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        for (int k = 1; k <= 11; k++) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_result", 64'(bus.data_result), 64'd0);
        check("midrst_exception", 64'(bus.data_exception), 64'd0);
        check("midrst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) pulses++;
        end
        check("midrst_no_rdy", 64'(pulses), 64'd0);

        run_op("mul_div_both", 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, MUL_CYC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
